// File: rtl/gray_stream.sv
// Pipelined RGB-to-grayscale converter with valid/ready streaming, selectable
// coefficient sets and per-pixel frame tags (sof/eol/eof).
module gray_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 300,
    parameter int unsigned IMG_H  = 400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] red_in,
    input  logic [DATA_W-1:0] green_in,
    input  logic [DATA_W-1:0] blue_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] gray_out,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              frame_done
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned PW = DATA_W + 8;
    localparam int unsigned SW = DATA_W + 10;

    localparam logic [1:0] ModeBt601 = 2'd0;
    localparam logic [1:0] ModeBt709 = 2'd1;
    localparam logic [1:0] ModeAvg   = 2'd2;
    localparam logic [1:0] ModeGreen = 2'd3;

    logic          en;
    logic          in_xfer;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [1:0]    mode_q;
    logic          at_sof;
    logic          at_eol;
    logic          at_eof;
    logic [1:0]    pix_mode;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign in_xfer  = in_valid && en;

    assign at_sof   = (col_q == '0) && (row_q == '0);
    assign at_eol   = (col_q == CW'(IMG_W - 1));
    assign at_eof   = at_eol && (row_q == RW'(IMG_H - 1));
    // The sof pixel already uses the mode presented alongside it.
    assign pix_mode = at_sof ? mode : mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= ModeBt601;
        end else if (in_xfer) begin
            if (at_sof) begin
                mode_q <= mode;
            end
            if (at_eol) begin
                col_q <= '0;
                row_q <= at_eof ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Stage 1: registered channels, tags and effective mode.
    logic              s1_valid;
    logic [DATA_W-1:0] s1_r;
    logic [DATA_W-1:0] s1_g;
    logic [DATA_W-1:0] s1_b;
    logic [1:0]        s1_mode;
    logic              s1_sof;
    logic              s1_eol;
    logic              s1_eof;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
            s1_mode  <= ModeBt601;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_r     <= red_in;
            s1_g     <= green_in;
            s1_b     <= blue_in;
            s1_mode  <= pix_mode;
            s1_sof   <= at_sof;
            s1_eol   <= at_eol;
            s1_eof   <= at_eof;
        end
    end

    logic [7:0]    coef_r;
    logic [7:0]    coef_g;
    logic [7:0]    coef_b;
    logic [PW-1:0] prod_r;
    logic [PW-1:0] prod_g;
    logic [PW-1:0] prod_b;

    always_comb begin
        coef_r = 8'd77;
        coef_g = 8'd150;
        coef_b = 8'd29;
        unique case (s1_mode)
            ModeBt601: begin coef_r = 8'd77; coef_g = 8'd150; coef_b = 8'd29; end
            ModeBt709: begin coef_r = 8'd54; coef_g = 8'd183; coef_b = 8'd19; end
            ModeAvg:   begin coef_r = 8'd85; coef_g = 8'd86;  coef_b = 8'd85; end
            ModeGreen: begin coef_r = 8'd0;  coef_g = 8'd0;   coef_b = 8'd0;  end
        endcase
    end

    assign prod_r = PW'(s1_r) * PW'(coef_r);
    assign prod_g = PW'(s1_g) * PW'(coef_g);
    assign prod_b = PW'(s1_b) * PW'(coef_b);

    // Stage 2: products, plus green carried for the passthrough mode.
    logic              s2_valid;
    logic [PW-1:0]     s2_pr;
    logic [PW-1:0]     s2_pg;
    logic [PW-1:0]     s2_pb;
    logic [DATA_W-1:0] s2_g;
    logic              s2_green;
    logic              s2_sof;
    logic              s2_eol;
    logic              s2_eof;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_pr    <= '0;
            s2_pg    <= '0;
            s2_pb    <= '0;
            s2_g     <= '0;
            s2_green <= 1'b0;
            s2_sof   <= 1'b0;
            s2_eol   <= 1'b0;
            s2_eof   <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_pr    <= prod_r;
            s2_pg    <= prod_g;
            s2_pb    <= prod_b;
            s2_g     <= s1_g;
            s2_green <= (s1_mode == ModeGreen);
            s2_sof   <= s1_sof;
            s2_eol   <= s1_eol;
            s2_eof   <= s1_eof;
        end
    end

    logic [SW-1:0]     sum;
    logic [DATA_W-1:0] gray_d;

    // Coefficients sum to 256, so sum >> 8 always fits in DATA_W.
    assign sum    = SW'(s2_pr) + SW'(s2_pg) + SW'(s2_pb);
    assign gray_d = s2_green ? s2_g : DATA_W'(sum >> 8);

    // Stage 3: output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            gray_out  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            gray_out  <= gray_d;
            out_sof   <= s2_sof;
            out_eol   <= s2_eol;
            out_eof   <= s2_eof;
        end
    end

    assign frame_done = out_valid && out_ready && out_eof;

endmodule

// File: doc/gray_stream.md
Name: gray_stream

Overview:
- Parametrised, pipelined RGB-to-grayscale converter; successor to the fixed 8-bit combinational gray block.
- Adds a valid/ready stream on both sides, run-time selectable coefficient sets, and frame geometry tracking.
- Sits between the RGB pixel source (file loader or sensor front end) and grayscale consumers: edge, threshold and file-dump blocks.
- Emits start-of-frame, end-of-line and end-of-frame tags aligned with each output pixel.

Parameters:
- DATA_W, 8, bits per colour channel and per gray output.
- IMG_W, 300, pixels per line.
- IMG_H, 400, lines per frame.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- mode  in  2  coefficient select; sampled only at start of frame.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel.
- red_in  in  DATA_W  red channel.
- green_in  in  DATA_W  green channel.
- blue_in  in  DATA_W  blue channel.
- out_valid  out  1  gray_out and tags valid.
- out_ready  in  1  downstream accepts the output pixel.
- gray_out  out  DATA_W  gray pixel.
- out_sof  out  1  output pixel is the first pixel of the frame.
- out_eol  out  1  output pixel is the last pixel of its line.
- out_eof  out  1  output pixel is the last pixel of the frame.
- frame_done  out  1  one-cycle pulse when the eof pixel transfers at the output.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Output data and tags are held stable while out_valid && !out_ready.
- Pipeline: 3 stages.
  - S1 registers R, G, B and tags.
  - S2 registers the three products.
  - S3 registers the sum >> 8.
- Stall and latency:
  - Global enable en = !out_valid || out_ready. All stages advance only when en is high.
  - in_ready = en.
  - Bubbles propagate; they are not compressed.
  - Latency is 3 cycles from input transfer to out_valid when out_ready is held high. Sustained throughput is 1 pixel/clk.
- Arithmetic:
  - Coefficients are 8-bit unsigned and each set sums to 256.
  - Products are DATA_W+8 bits; the sum is DATA_W+10 bits.
  - gray = floor(sum / 256), truncated, no rounding. The result always fits in DATA_W; no saturation is needed.
- Modes:
  - 0: BT.601, coefficients 77 / 150 / 29.
  - 1: BT.709, coefficients 54 / 183 / 19.
  - 2: average, coefficients 85 / 86 / 85.
  - 3: green passthrough; gray = G.
- Mode latching:
  - The mode register loads on the input transfer with col == 0 and row == 0.
  - That transfer and all pixels to the end of the frame use the latched value.
  - Mode changes mid-frame are ignored until the next frame.
- Counters:
  - col (0..IMG_W-1) and row (0..IMG_H-1) advance on each input transfer.
  - col wraps to 0 at IMG_W-1 and row increments on that wrap.
  - At col == IMG_W-1 and row == IMG_H-1, both wrap to 0.
- Tags:
  - sof = (col == 0 && row == 0).
  - eol = (col == IMG_W-1).
  - eof = eol && (row == IMG_H-1).
  - Tags are computed at input and travel with the pixel through all stages.
- frame_done is asserted in the cycle out_valid && out_ready && out_eof; it is 0 otherwise.
- Reset values (all outputs 0):
  - out_valid = 0; gray_out = 0; out_sof = out_eol = out_eof = 0; frame_done = 0.
  - in_ready = 1 the cycle after reset deasserts.
  - col = row = 0; latched mode = 0; all stage valids = 0.
- Reset mid-frame:
  - In-flight pixels are discarded and no frame_done is produced.
  - The next accepted pixel is sof.
- Simultaneous events:
  - Input transfer and output transfer in the same cycle are both honoured; the pipeline shifts by one.
  - rst has priority over all other events.

Test Plan:
- Reset, then stream 1 pixel (255, 0, 0) with out_ready = 1:
  - mode 0 -> gray_out = 76 three cycles later, out_sof = 1.
  - mode 1 -> gray_out = 53.
- Pixel (100, 150, 200):
  - mode 0 -> 140; mode 1 -> 143; mode 2 -> 150; mode 3 -> 150.
  - (255, 255, 255) -> 255 in modes 0, 1 and 2.
- Full 300x400 frame, back-to-back, out_ready = 1:
  - 120000 outputs, one per cycle after the initial 3-cycle latency.
  - out_eol on every 300th output; out_eof and frame_done only on output 119999.
  - The next frame's first output has out_sof = 1.
- Random out_ready (50%) with random in_valid:
  - Output sequence matches a reference model pixel-for-pixel with no loss or duplication.
  - gray_out and tags stay stable during stalls.
  - in_ready = 0 whenever out_valid && !out_ready.
- Mode written 0 -> 1 at pixel 500 of a frame:
  - The whole frame is computed in mode 0.
  - The next frame's pixel 0 onward is computed in mode 1.
- Assert rst for 1 cycle at pixel 1000 with 3 pixels in flight:
  - out_valid = 0 the next cycle and no frame_done.
  - The next accepted pixel emerges with out_sof = 1.
